// File: rtl/out_dev_ctrl_pkg.sv
// Output device controller: shared types.
// State encoding and device register word addresses.
package out_dev_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WR_PREV,
    S_WR_CUR,
    S_ACK
  } state_e;

  localparam logic [1:0] ADDR_PREV = 2'b00;
  localparam logic [1:0] ADDR_CUR  = 2'b01;

endpackage

// File: rtl/out_dev_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// On a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_id,
  output logic gnt_vld
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (req0 & req1):  gnt_id = ~last;
      (req1 & ~req0): gnt_id = 1'b1;
      default:        gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/out_dev_ctrl.sv
// Output device controller: arbitrates two requesters and
// shifts the device's current value into prev before writing cur.
module out_dev_ctrl
  import out_dev_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [31:0]      wdata0,
  input  logic [31:0]      wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             dev_en,
  output logic [1:0]       dev_addr,
  output logic [31:0]      dev_din,
  input  logic [31:0]      dev_dout,
  output logic             busy,
  output logic [CNT_W-1:0] upd_cnt
);

  state_e           state_q;
  state_e           state_d;
  logic [31:0]      data_q;
  logic [31:0]      hold_q;
  logic             gnt_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_id;
  logic             gnt_vld;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .last    (last_q),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (gnt_vld) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WR_PREV;
      S_WR_PREV: state_d = S_WR_CUR;
      S_WR_CUR:  state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Idle-like states park the address on cur so hold_q sees it.
  always_comb begin
    dev_en   = 1'b0;
    dev_addr = ADDR_CUR;
    dev_din  = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_WR_PREV: begin
        dev_en   = 1'b1;
        dev_addr = ADDR_PREV;
        dev_din  = hold_q;
      end
      S_WR_CUR: begin
        dev_en   = 1'b1;
        dev_addr = ADDR_CUR;
        dev_din  = data_q;
      end
      S_ACK: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      hold_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && gnt_vld) begin
        data_q <= gnt_id ? wdata1 : wdata0;
        gnt_q  <= gnt_id;
        last_q <= gnt_id;
      end
      if (state_q == S_CAPTURE)
        hold_q <= dev_dout;
      if (state_q == S_ACK)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_out_dev_ctrl.sv
// Scoreboard bench for out_dev_ctrl with a two-register device model.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_out_dev_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic        dev_en;
  logic [1:0]  dev_addr;
  logic [31:0] dev_din;
  logic [31:0] dev_dout;
  logic        busy;
  logic [3:0]  upd_cnt;

  logic [31:0] dev_prev = 32'h0;
  logic [31:0] dev_cur  = 32'h11;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] data;
    logic [31:0] prev;
    logic [3:0]  cnt;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_cur = 32'h11;
  logic [3:0]  m_cnt = 4'd0;

  out_dev_ctrl #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .dev_en   (dev_en),
    .dev_addr (dev_addr),
    .dev_din  (dev_din),
    .dev_dout (dev_dout),
    .busy     (busy),
    .upd_cnt  (upd_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dev_dout = (dev_addr == 2'b00) ? dev_prev :
                    (dev_addr == 2'b01) ? dev_cur : 32'h0;

  always @(posedge clk) begin
    if (dev_en && dev_addr == 2'b00) dev_prev <= dev_din;
    if (dev_en && dev_addr == 2'b01) dev_cur  <= dev_din;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  // Expected ack for a grant whose req was raised at negedge cycle c.
  task automatic push_exp(input bit id, input logic [31:0] d,
                          input int at);
    exp_t e;
    e.ack  = id ? 2'b10 : 2'b01;
    e.data = d;
    e.prev = m_cur;
    e.cnt  = m_cnt;
    e.at   = at;
    exp_q.push_back(e);
    m_cur = d;
    m_cnt = m_cnt + 4'd1;
  endtask

  // Monitor: ack scoreboard plus prev-then-cur write ordering.
  logic was_wr_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_id", {30'd0, ack1, ack0}, {30'd0, e.ack});
          check("ack_time", cyc, e.at);
          check("dev_cur", dev_cur, e.data);
          check("dev_prev", dev_prev, e.prev);
          check("upd_cnt", {28'd0, upd_cnt}, {28'd0, e.cnt});
        end
      end
      if (dev_en && dev_addr == 2'b01)
        check("wr_order", {31'd0, was_wr_prev}, 32'd1);
    end
    was_wr_prev = dev_en && (dev_addr == 2'b00);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_dev_en", {31'd0, dev_en}, 32'd0);
    check("rst_dev_addr", {30'd0, dev_addr}, 32'd1);
    check("rst_dev_din", dev_din, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    check("rst_upd_cnt", {28'd0, upd_cnt}, 32'd0);
    m_cnt = 4'd0;
    rst_n = 1'b1;
  endtask

  // One-cycle request; alt replaces wdata right after the grant edge.
  task automatic single(input bit id, input logic [31:0] d,
                        input logic [31:0] alt);
    push_exp(id, d, cyc + 4);
    if (id) begin req1 = 1'b1; wdata1 = d; end
    else    begin req0 = 1'b1; wdata0 = d; end
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    if (id) wdata1 = alt; else wdata0 = alt;
    check("busy_capture", {31'd0, busy}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("busy_active", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    rst_n  = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    wdata0 = 32'h0;
    wdata1 = 32'h0;
    @(negedge clk);
    do_reset();

    // Basic update: prev <- 0x11, cur <- 0xAA.
    single(1'b0, 32'hAA, 32'hAA);

    // wdata changed after grant is ignored.
    single(1'b0, 32'hAA, 32'h55);

    // Back-to-back single requests.
    single(1'b0, 32'hA, 32'hA);
    single(1'b0, 32'hB, 32'hB);
    check("b2b_prev", dev_prev, 32'hA);
    check("b2b_cur", dev_cur, 32'hB);

    // Round-robin from reset with both held until their acks.
    do_reset();
    c = cyc;
    push_exp(1'b0, 32'h0A0A, c + 4);
    push_exp(1'b1, 32'hB1B1, c + 9);
    push_exp(1'b0, 32'h0A0A, c + 14);
    push_exp(1'b1, 32'hB1B1, c + 19);
    wdata0 = 32'h0A0A;
    wdata1 = 32'hB1B1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 14) req0 = 1'b0;
      if (k == 19) req1 = 1'b0;
    end
    check("rr_busy_idle", {31'd0, busy}, 32'd0);

    // Reset during WR_PREV aborts before the cur write.
    wdata0 = 32'hDEAD;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    check("abort_in_wr_prev", {29'd0, dev_en, dev_addr}, 32'h4);
    do_reset();
    check("abort_cur_kept", dev_cur, m_cur);
    check("abort_prev_written", dev_prev, m_cur);
    @(negedge clk);

    // Sixteen completions wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++)
      single(i[0], 32'h100 + i, 32'h100 + i);
    check("cnt_wrap", {28'd0, upd_cnt}, 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/out_dev_ctrl.md
OUT_DEV_CTRL -- requirements
Module: out_dev_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the completed-update counter.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  update request from requester 0 (CPU store path) and requester 1 (debug/host).
REQ-005 wdata0, wdata1  input  32 each  new display value from each requester.
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-007 dev_en  output  1  write enable to output device.
REQ-008 dev_addr  output  2  device word address [3:2]; 00 = previous-value register, 01 = current-value register.
REQ-009 dev_din  output  32  write data to device.
REQ-010 dev_dout  input  32  combinational read data from device at dev_addr.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 upd_cnt  output  CNT_W  number of completed updates, wraps modulo 2^CNT_W.

Function
REQ-013 FSM states IDLE, CAPTURE, WR_PREV, WR_CUR, ACK; one state per cycle outside IDLE.
REQ-014 IDLE: if any req high, grant one, latch its wdata into data_q, record grant id, go CAPTURE; else stay.
REQ-015 Arbitration round-robin: both high -> grant the requester not granted last; after reset requester 0 wins first tie.
REQ-016 CAPTURE: dev_addr=01, dev_en=0; capture dev_dout into hold_q; go WR_PREV.
REQ-017 WR_PREV: dev_en=1, dev_addr=00, dev_din=hold_q; go WR_CUR.
REQ-018 WR_CUR: dev_en=1, dev_addr=01, dev_din=data_q; go ACK.
REQ-019 ACK: ack of granted requester high exactly this cycle, other ack low; upd_cnt increments by 1; go IDLE.
REQ-020 Latency: req sampled at edge T -> ack high during cycle T+4; next request can be granted at edge T+5.
REQ-021 IDLE/CAPTURE/ACK outputs: dev_en=0, dev_addr=01, dev_din=0.
REQ-022 wdata changes after grant are ignored; transaction uses data_q.
REQ-023 req dropped after grant: transaction still completes and ack still pulses.
REQ-024 Requester holding req through its ack is treated as a new request in the following IDLE, subject to round-robin.
REQ-025 Requests arriving while busy are not queued internally; they are seen only if still high in IDLE.
REQ-026 upd_cnt at all-ones increments to zero; no saturation flag.

Reset
REQ-027 rst_n low at a clock edge: state=IDLE, ack0=ack1=0, dev_en=0, dev_addr=01, dev_din=0, busy=0, upd_cnt=0, data_q=hold_q=0, last-grant=requester 1.
REQ-028 Reset mid-transaction aborts without further dev_en; device contents already written are not restored; no ack issued.

Structure
REQ-029 Shared package holds state encoding enum and address constants ADDR_PREV=2'b00, ADDR_CUR=2'b01.
REQ-030 Round-robin selection in sub-module rr_arb2 (inputs req0, req1, last; outputs grant id, grant valid); FSM and datapath in out_dev_ctrl.

Verification
REQ-031 Device model with cur=0x11, req0 with wdata0=0xAA for 1 cycle -> dev writes 00<-0x11 then 01<-0xAA on consecutive cycles, ack0 at T+4, upd_cnt=1.
REQ-032 req0 and req1 high together from reset, held until each ack -> grant order 0,1,0,1; each ack pulses once per grant.
REQ-033 wdata0 changed 0xAA->0x55 one cycle after grant -> device cur=0xAA.
REQ-034 rst_n low during WR_PREV -> no WR_CUR write, no ack, all outputs at reset values next cycle.
REQ-035 Preload upd_cnt path with 2^CNT_W completions (CNT_W=4 build, 16 updates) -> upd_cnt returns to 0.
REQ-036 Back-to-back single requests 0xA then 0xB -> device prev=0xA, cur=0xB, busy low only in the IDLE cycle between them.
